multicycle_control_fsm: RTL and testbench
=========================================

Name: multicycle_control_fsm

Overview:
- Main control unit for the multicycle RISC-V datapath, in the Patterson–Hennessy style.
- Moore state machine that sequences fetch, decode, execute, memory and writeback for each instruction.
- Decodes the 7-bit opcode and drives all datapath mux selects, register/memory enables and PC write controls.

Parameters:
- OP_LW, 7'b0000011, load-word opcode
- OP_SW, 7'b0100011, store-word opcode
- OP_RTYPE, 7'b0110011, register ALU opcode
- OP_ITYPE, 7'b0010011, immediate ALU opcode
- OP_BEQ, 7'b1100011, branch-equal opcode

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high; forces state S0
- opcode  in  7  instruction[6:0] from instruction register
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  0=PC, 1=register A
- MemRead  out  1  memory read enable
- MemWrite  out  1  memory write enable
- MemtoReg  out  1  writeback source: 0=ALUOut, 1=memory data register
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- IRWrite  out  1  instruction register load
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write if ALU Zero
- PCSource  out  1  0=ALU result, 1=ALUOut
- ALUOp  out  2  00=add, 01=subtract (branch compare), 10=decode funct fields
- ALUSrcB  out  2  00=register B, 01=constant 4, 10=immediate

Behaviour:
- One state register, 4 bits. States S0..S9.
- On a rising clk edge with reset=1, state <= S0. Otherwise state <= next state.
- Outputs are purely combinational from the current state (Moore). opcode does not affect outputs directly.
- Every output not listed for a state is 0.
- While reset is held, S0 outputs are driven.
- The datapath gates its own registers during reset.
- S0 Fetch: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcA=0, IorD=0, ALUSrcB=01, ALUOp=00, PCSource=0. Next: S1.
- S1 Decode: ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target precompute). Next is chosen from opcode sampled at this edge:
  - LW or SW -> S2
  - RTYPE -> S6
  - ITYPE -> S9
  - BEQ -> S8
  - any other value, including X/Z -> S0
- S2 MemAddr: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next from opcode: LW -> S3, SW -> S5, else S0.
- S3 MemRead: MemRead=1, IorD=1. Next: S4.
- S4 MemWriteback: RegWrite=1, MemtoReg=1. Next: S0.
- S5 MemWrite: MemWrite=1, IorD=1. Next: S0.
- S6 ExecuteR: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: S7.
- S7 ALUWriteback: RegWrite=1, MemtoReg=0. Next: S0.
- S8 Branch: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1. Next: S0.
- S9 ExecuteI: ALUSrcA=1, ALUSrcB=10, ALUOp=10. Next: S7.
- Unused encodings (10..15) go to S0 next cycle, with all outputs 0.
- Instruction length in cycles:
  - LW: 5 (S0, S1, S2, S3, S4)
  - SW: 4
  - R-type and I-type: 4
  - BEQ: 3
- Reset asserted mid-instruction aborts it; the state is S0 after that edge.
- opcode is sampled only on edges leaving S1 and S2. It must be stable from the IR load in S0 through the S2 exit edge.
- At most one of MemRead or MemWrite is asserted in any state.

Test Plan:
- Reset=1 for one edge, then release → S0 outputs: MemRead=1, ALUSrcA=0, IorD=0, IRWrite=1, ALUSrcB=1, ALUOp=0, PCWrite=1, PCSource=0.
- opcode=7'b0000011 held from reset → successive cycles show:
  - S1: ALUSrcA=0, ALUSrcB=2, ALUOp=0
  - S2: ALUSrcA=1, ALUSrcB=2, ALUOp=0
  - S3: MemRead=1, IorD=1
  - S4: RegWrite=1, MemtoReg=1
  - then S0 fetch values again
- opcode=7'b0100011 → S2 then S5 with MemWrite=1, IorD=1, MemRead=0, then S0; loop is 4 cycles.
- opcode=7'b0110011 → S6 (ALUSrcA=1, ALUSrcB=0, ALUOp=2), then S7 (RegWrite=1, MemtoReg=0), then S0. opcode=7'b0010011 → S9 (ALUSrcB=2, ALUOp=2), then S7.
- opcode=7'b1100011 → S8: PCWriteCond=1, PCSource=1, ALUOp=1, ALUSrcA=1, ALUSrcB=0, PCWrite=0; then S0.
- Illegal opcode 7'b1111111 in S1 → S0 next cycle. Reset asserted during S3 of an LW → S0 outputs after the next edge, with no S4 RegWrite pulse.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for a multicycle RISC-V datapath: fetch, decode, execute, memory, writeback.
// Control outputs are registered from the next state, so they always reflect the current state.
module multicycle_control_fsm #(
  parameter logic [6:0] OP_LW    = 7'b0000011,
  parameter logic [6:0] OP_SW    = 7'b0100011,
  parameter logic [6:0] OP_RTYPE = 7'b0110011,
  parameter logic [6:0] OP_ITYPE = 7'b0010011,
  parameter logic [6:0] OP_BEQ   = 7'b1100011
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IorD,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAddr  = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StAluWb    = 4'd7,
    StBranch   = 4'd8,
    StExecI    = 4'd9
  } state_e;

  state_e      state_q, state_d;
  logic [13:0] ctrl_q;

  // Order: RegWrite ALUSrcA MemRead MemWrite MemtoReg IorD IRWrite PCWrite PCWriteCond PCSource
  //        ALUOp[1:0] ALUSrcB[1:0]
  function automatic logic [13:0] ctrl_of(input state_e s);
    logic [13:0] c;
    c = '0;
    case (s)
      StFetch:    c = {10'b0010001100, 2'b00, 2'b01};
      StDecode:   c = {10'b0000000000, 2'b00, 2'b10};
      StMemAddr:  c = {10'b0100000000, 2'b00, 2'b10};
      StMemRead:  c = {10'b0010010000, 2'b00, 2'b00};
      StMemWb:    c = {10'b1000100000, 2'b00, 2'b00};
      StMemWrite: c = {10'b0001010000, 2'b00, 2'b00};
      StExecR:    c = {10'b0100000000, 2'b10, 2'b00};
      StAluWb:    c = {10'b1000000000, 2'b00, 2'b00};
      StBranch:   c = {10'b0100000011, 2'b01, 2'b00};
      StExecI:    c = {10'b0100000000, 2'b10, 2'b10};
      default:    c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        // Unknown or X/Z opcodes fall through to the default and restart fetch.
        case (opcode)
          OP_LW, OP_SW: state_d = StMemAddr;
          OP_RTYPE:     state_d = StExecR;
          OP_ITYPE:     state_d = StExecI;
          OP_BEQ:       state_d = StBranch;
          default:      state_d = StFetch;
        endcase
      end
      StMemAddr: begin
        case (opcode)
          OP_LW:   state_d = StMemRead;
          OP_SW:   state_d = StMemWrite;
          default: state_d = StFetch;
        endcase
      end
      StMemRead: state_d = StMemWb;
      StExecR:   state_d = StAluWb;
      StExecI:   state_d = StAluWb;
      default:   state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch;
      ctrl_q  <= ctrl_of(StFetch);
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_of(state_d);
    end
  end

  assign {RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD, IRWrite, PCWrite, PCWriteCond,
          PCSource, ALUOp, ALUSrcB} = ctrl_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm: per-instruction expected control vectors are queued
// when the opcode is driven and popped one per cycle against the DUT outputs.
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD, IRWrite;
  logic       PCWrite, PCWriteCond, PCSource;
  logic [1:0] ALUOp, ALUSrcB;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  logic [13:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IorD        (IorD),
    .IRWrite     (IRWrite),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB)
  );

  task automatic check_eq(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  function automatic logic [13:0] vec(input bit rw, input bit asa, input bit mr, input bit mw,
                                      input bit m2r, input bit iord, input bit irw, input bit pcw,
                                      input bit pcwc, input bit pcs, input bit [1:0] aop,
                                      input bit [1:0] asb);
    return {rw, asa, mr, mw, m2r, iord, irw, pcw, pcwc, pcs, aop, asb};
  endfunction

  // Expected outputs per state, written directly from the state table.
  function automatic logic [13:0] exp_state(input int s);
    case (s)
      0: return vec(0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 2'd0, 2'd1);
      1: return vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2);
      2: return vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd2);
      3: return vec(0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
      4: return vec(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      5: return vec(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 2'd0, 2'd0);
      6: return vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd0);
      7: return vec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0);
      8: return vec(0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 2'd1, 2'd0);
      9: return vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2'd2, 2'd2);
      default: return '0;
    endcase
  endfunction

  function automatic logic [13:0] observed();
    return {RegWrite, ALUSrcA, MemRead, MemWrite, MemtoReg, IorD, IRWrite, PCWrite, PCWriteCond,
            PCSource, ALUOp, ALUSrcB};
  endfunction

  task automatic push(input int s, input string nm);
    exp_q.push_back(exp_state(s));
    tag_q.push_back($sformatf("%s_S%0d", nm, s));
  endtask

  // Compare the head of the scoreboard against the current outputs, then advance one cycle.
  task automatic pop_step();
    logic [13:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check_eq(t, observed(), e);
    @(posedge clk);
    #1;
  endtask

  // Drive an opcode while in fetch and walk the expected state sequence.
  task automatic run_instr(input logic [6:0] op, input string nm);
    opcode = op;
    push(0, nm);
    push(1, nm);
    case (op)
      7'b0000011: begin push(2, nm); push(3, nm); push(4, nm); end
      7'b0100011: begin push(2, nm); push(5, nm); end
      7'b0110011: begin push(6, nm); push(7, nm); end
      7'b0010011: begin push(9, nm); push(7, nm); end
      7'b1100011: push(8, nm);
      default: ;
    endcase
    while (exp_q.size() != 0) pop_step();
  endtask

  initial begin
    reset  = 1'b1;
    opcode = 7'b0000011;
    @(posedge clk);
    #1;
    check_eq("reset_held", observed(), exp_state(0));
    reset = 1'b0;

    run_instr(7'b0000011, "lw");
    run_instr(7'b0100011, "sw");
    run_instr(7'b0110011, "rtype");
    run_instr(7'b0010011, "itype");
    run_instr(7'b1100011, "beq");
    run_instr(7'b1111111, "illegal");
    run_instr(7'bxxxxxxx, "xop");
    run_instr(7'b1100011, "beq2");

    // LW aborted by reset while in S3: no S4 write-back pulse.
    opcode = 7'b0000011;
    push(0, "lw_abort");
    push(1, "lw_abort");
    push(2, "lw_abort");
    while (exp_q.size() != 0) pop_step();
    check_eq("abort_S3", observed(), exp_state(3));
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("abort_reset_S0", observed(), exp_state(0));
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_after_S1", observed(), exp_state(1));
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;

    run_instr(7'b0100011, "sw2");
    check_eq("final_S0", observed(), exp_state(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
